pwm_duty_decoder: RTL and testbench

Recovers the signed drive command from one motor's fwd/rev PWM pair, the inverse of the motor controller's command-to-PWM path. It measures fwd-only, rev-only and both-high cycles over a fixed window equal to the PWM period. At the end of each window it reports a signed 11-bit duty plus brake and fault flags. One instance per motor (left, right) sits on the controller outputs for self-check and closed-loop verification.

---
 rtl/pwm_duty_decoder.sv | 101 ++++++++++
 tb/tb_pwm_duty_decoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// Recovers the signed drive command from a motor's fwd/rev PWM pair by counting
// fwd-only, rev-only and both-high cycles over a free-running 2^CNT_W window.
module pwm_duty_decoder #(
  parameter int CNT_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fwd,
  input  logic                    rev,
  output logic signed [CNT_W:0]   duty,
  output logic                    duty_vld,
  output logic                    brake,
  output logic                    fault
);

  localparam logic [CNT_W:0]   FULL     = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0]   ONE_ACC  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] WIN_LAST = {CNT_W{1'b1}};

  logic             fwd_q, rev_q;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W:0]   f_acc, r_acc, b_acc;
  logic             is_f, is_r, is_b;
  logic [CNT_W:0]   f_fin, r_fin, b_fin;
  logic signed [CNT_W:0] duty_nxt;
  logic             brake_nxt, fault_nxt;

  // A full-window count of N would land on the sign bit; hold it at N-1.
  function automatic logic [CNT_W-1:0] sat_mag(input logic [CNT_W:0] cnt);
    return cnt[CNT_W] ? {CNT_W{1'b1}} : cnt[CNT_W-1:0];
  endfunction

  function automatic logic signed [CNT_W:0] to_duty(input logic [CNT_W-1:0] mag,
                                                    input logic neg);
    logic signed [CNT_W:0] m;
    m = $signed({1'b0, mag});
    return neg ? -m : m;
  endfunction

  assign is_f = fwd_q & ~rev_q;
  assign is_r = rev_q & ~fwd_q;
  assign is_b = fwd_q & rev_q;

  // Running totals including this cycle's sample; these become the window
  // finals on the closing cycle.
  assign f_fin = f_acc + (is_f ? ONE_ACC : '0);
  assign r_fin = r_acc + (is_r ? ONE_ACC : '0);
  assign b_fin = b_acc + (is_b ? ONE_ACC : '0);

  always_comb begin
    duty_nxt  = '0;
    brake_nxt = 1'b0;
    fault_nxt = 1'b0;
    if (b_fin == FULL) begin
      brake_nxt = 1'b1;
    end else if ((b_fin != '0) || ((f_fin != '0) && (r_fin != '0))) begin
      fault_nxt = 1'b1;
    end else if (f_fin != '0) begin
      duty_nxt = to_duty(sat_mag(f_fin), 1'b0);
    end else if (r_fin != '0) begin
      duty_nxt = to_duty(sat_mag(r_fin), 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q    <= 1'b0;
      rev_q    <= 1'b0;
      win_cnt  <= '0;
      f_acc    <= '0;
      r_acc    <= '0;
      b_acc    <= '0;
      duty     <= '0;
      brake    <= 1'b0;
      fault    <= 1'b0;
      duty_vld <= 1'b0;
    end else begin
      // input sample stage
      fwd_q   <= fwd;
      rev_q   <= rev;
      win_cnt <= win_cnt + ONE_CNT;
      // accumulate / window-close stage
      if (win_cnt == WIN_LAST) begin
        duty     <= duty_nxt;
        brake    <= brake_nxt;
        fault    <= fault_nxt;
        duty_vld <= 1'b1;
        f_acc    <= '0;
        r_acc    <= '0;
        b_acc    <= '0;
      end else begin
        duty_vld <= 1'b0;
        f_acc    <= f_fin;
        r_acc    <= r_fin;
        b_acc    <= b_fin;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench for pwm_duty_decoder: stimulus pushes expected window
// results computed from per-window class counts; a monitor pops on duty_vld.
module tb_pwm_duty_decoder;

  localparam int CNT_W = 10;
  localparam int N     = 1 << CNT_W;

  typedef struct packed {
    logic              brake;
    logic              fault;
    logic [CNT_W:0]    duty;
  } exp_t;

  logic                  clk, rst, fwd, rev;
  logic signed [CNT_W:0] duty;
  logic                  duty_vld, brake, fault;

  int   tests = 0;
  int   fails = 0;
  int   win_no = 0;
  int   ecnt;
  int   fc, rc, bc;
  exp_t exp_q[$];

  pwm_duty_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fwd(fwd), .rev(rev),
    .duty(duty), .duty_vld(duty_vld), .brake(brake), .fault(fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t ref_result(input int f, input int r, input int b);
    exp_t e;
    int   d;
    e = '0;
    d = 0;
    if (b == N)                         e.brake = 1'b1;
    else if (b > 0 || (f > 0 && r > 0)) e.fault = 1'b1;
    else if (f > 0)                     d = (f < N - 1) ? f : N - 1;
    else if (r > 0)                     d = -((r < N - 1) ? r : N - 1);
    e.duty = (CNT_W+1)'(d);
    return e;
  endfunction

  task automatic check(input string name, input logic [CNT_W+2:0] act,
                       input logic [CNT_W+2:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got brake/fault/duty=%b/%b/%h expected %b/%b/%h", name,
               act[CNT_W+2], act[CNT_W+1], act[CNT_W:0],
               expv[CNT_W+2], expv[CNT_W+1], expv[CNT_W:0]);
    end
  endtask

  // Value applied now is registered at edge ecnt and counted one edge later;
  // the window closes at the edge whose index is N-1 mod N.
  task automatic drive(input logic f, input logic r);
    fwd = f;
    rev = r;
    if (f && !r)      fc++;
    else if (r && !f) rc++;
    else if (f && r)  bc++;
    if ((ecnt + 2) % N == 0) begin
      exp_q.push_back(ref_result(fc, rc, bc));
      fc = 0; rc = 0; bc = 0;
    end
    ecnt++;
    @(negedge clk);
  endtask

  task automatic pwm_windows(input int nwin, input int f_hi, input int r_hi,
                             input int r_off);
    int p;
    for (int i = 0; i < nwin * N; i++) begin
      p = i % N;
      drive(p < f_hi, (p >= r_off) && (p < r_off + r_hi));
    end
  endtask

  task automatic model_reset();
    ecnt = 0; fc = 0; rc = 0; bc = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && duty_vld) begin
      win_no++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_vld: duty_vld high at window %0d, expected none", win_no);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("window_%0d", win_no), {brake, fault, duty}, e);
      end
    end
  end

  initial begin
    rst = 1'b1; fwd = 1'b0; rev = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", {brake, fault, duty}, '0);
    tests++;
    if (duty_vld !== 1'b0) begin
      fails++;
      $display("FAIL reset_vld: got %b expected 0", duty_vld);
    end
    rst = 1'b0;

    pwm_windows(3, 512, 0, 0);      // forward 50%
    pwm_windows(3, 0, 300, 0);      // reverse 300
    pwm_windows(3, N, 0, 0);        // full forward
    pwm_windows(3, 0, N, 0);        // full reverse
    pwm_windows(3, N, N, 0);        // brake
    pwm_windows(3, 0, 0, 0);        // coast
    pwm_windows(2, 200, 1, 100);    // shoot-through overlap
    pwm_windows(2, 200, 50, 600);   // disjoint mixed drive

    for (int w = 0; w < 15; w++) begin
      case ($urandom_range(0, 3))
        0: pwm_windows(1, int'($urandom_range(0, N)), 0, 0);
        1: pwm_windows(1, 0, int'($urandom_range(0, N)), 0);
        2: pwm_windows(1, int'($urandom_range(0, N)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, N - 1)));
        default:
          for (int i = 0; i < N; i++)
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      endcase
    end

    while (ecnt % N != 500) drive(1'b1, 1'b0);
    rst = 1'b1;
    fwd = 1'b0;
    rev = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", {brake, fault, duty}, '0);
    tests++;
    if (duty_vld !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_vld: got %b expected 0", duty_vld);
    end
    rst = 1'b0;
    model_reset();
    pwm_windows(3, 700, 0, 0);

    repeat (4) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_results: got %0d unconsumed expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
